// File: rtl/router_pkg.sv
// Shared router definitions: header field widths, header-word layout at the
// default widths, and the header-word builder shared by the encap/decap paths.
package router_pkg;

    localparam int TTL_W        = 2;
    localparam int PKT_NUM_W    = 5;
    localparam int SRC_ROUTER_W = 2;
    localparam int PKT_HDR_W    = TTL_W + PKT_NUM_W + SRC_ROUTER_W;

    typedef struct packed {
        logic [TTL_W-1:0]        ttl;
        logic [PKT_NUM_W-1:0]    pkt_number;
        logic [SRC_ROUTER_W-1:0] src_router;
    } pkt_hdr_t;

    // Bit positions inside a 64-bit header word with 10-bit addresses and 8-bit length.
    localparam int HW_DST_MSB = 63;
    localparam int HW_DST_LSB = 54;
    localparam int HW_HDR_MSB = 53;
    localparam int HW_HDR_LSB = 45;
    localparam int HW_LEN_MSB = 44;
    localparam int HW_LEN_LSB = 37;

    localparam int HDR_WORD_MAX_W = 256;
    typedef logic [HDR_WORD_MAX_W-1:0] hdr_word_t;

    function automatic hdr_word_t field_mask(input int width);
        return (hdr_word_t'(1) << width) - hdr_word_t'(1);
    endfunction

    // Packs {dst, hdr, len, zeros} MSB-aligned into a data_w-bit word; callers
    // truncate the result to their own word width.
    function automatic hdr_word_t build_header_word(
        input hdr_word_t dst,
        input hdr_word_t hdr,
        input hdr_word_t len,
        input int        data_w,
        input int        addr_w,
        input int        hdr_w,
        input int        len_w
    );
        hdr_word_t w;
        w = '0;
        w = w | ((dst & field_mask(addr_w)) << (data_w - addr_w));
        w = w | ((hdr & field_mask(hdr_w))  << (data_w - addr_w - hdr_w));
        w = w | ((len & field_mask(len_w))  << (data_w - addr_w - hdr_w - len_w));
        return w;
    endfunction

endpackage

// File: rtl/pkt_encapsulator.sv
// Router input-port-0 encapsulation: emits one header word on request, then
// streams PAYLOAD_WORDS words from the FWFT FIFO and pulses encap_done.
module pkt_encapsulator
    import router_pkg::*;
#(
    parameter int AURORA_DATA_WIDTH = 64,
    parameter int ADDR_WIDTH        = 10,
    parameter int HEADER_WIDTH      = 9,
    parameter int LEN_WIDTH         = 8,
    parameter int PAYLOAD_WORDS     = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start_encap_pkt,
    input  logic [ADDR_WIDTH-1:0]        router_dst_addr_send,
    input  logic [HEADER_WIDTH-1:0]      header_pkt_send,
    output logic                         encap_done,
    output logic                         busy,
    input  logic [AURORA_DATA_WIDTH-1:0] fifo_dout,
    input  logic                         fifo_empty,
    output logic                         fifo_rd_en,
    output logic [AURORA_DATA_WIDTH-1:0] tx_data,
    output logic                         tx_valid,
    input  logic                         tx_ready,
    output logic                         tx_last
);

    localparam int                   CNT_W     = $clog2(PAYLOAD_WORDS + 1);
    localparam logic [CNT_W-1:0]     LAST_IDX  = CNT_W'(PAYLOAD_WORDS - 1);
    localparam logic [LEN_WIDTH-1:0] LEN_FIELD = LEN_WIDTH'(PAYLOAD_WORDS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HEADER,
        S_PAYLOAD,
        S_DONE,
        S_RELEASE
    } state_t;

    state_t                   state_q, state_d;
    logic [ADDR_WIDTH-1:0]    dst_q,   dst_d;
    logic [HEADER_WIDTH-1:0]  hdr_q,   hdr_d;
    logic [CNT_W-1:0]         cnt_q,   cnt_d;
    logic [AURORA_DATA_WIDTH-1:0] header_word;
    logic                     pay_valid;

    assign header_word = AURORA_DATA_WIDTH'(build_header_word(
        hdr_word_t'(dst_q), hdr_word_t'(hdr_q), hdr_word_t'(LEN_FIELD),
        AURORA_DATA_WIDTH, ADDR_WIDTH, HEADER_WIDTH, LEN_WIDTH));

    assign pay_valid = !fifo_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            dst_q   <= '0;
            hdr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            dst_q   <= dst_d;
            hdr_q   <= hdr_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        dst_d      = dst_q;
        hdr_d      = hdr_q;
        cnt_d      = cnt_q;
        tx_data    = '0;
        tx_valid   = 1'b0;
        tx_last    = 1'b0;
        fifo_rd_en = 1'b0;
        encap_done = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start_encap_pkt) begin
                    state_d = S_HEADER;
                    dst_d   = router_dst_addr_send;
                    hdr_d   = header_pkt_send;
                    cnt_d   = '0;
                end
            end
            S_HEADER: begin
                tx_valid = 1'b1;
                tx_data  = header_word;
                if (tx_ready) begin
                    state_d = S_PAYLOAD;
                end
            end
            S_PAYLOAD: begin
                // FWFT head stays put until popped, so stalls keep tx_data stable.
                tx_valid   = pay_valid;
                tx_data    = fifo_dout;
                tx_last    = pay_valid && (cnt_q == LAST_IDX);
                fifo_rd_en = pay_valid && tx_ready;
                if (fifo_rd_en) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_IDX) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                encap_done = 1'b1;
                state_d    = S_RELEASE;
            end
            S_RELEASE: begin
                if (!start_encap_pkt) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_pkt_encapsulator.sv
// Directed bench for pkt_encapsulator with a FWFT FIFO model and a scoreboard
// of expected TX words checked on every accepted transfer.
module tb_pkt_encapsulator;

    localparam int DW = 64;
    localparam int AW = 10;
    localparam int HW = 9;
    localparam int LW = 8;
    localparam int PW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start_encap_pkt;
    logic [AW-1:0] router_dst_addr_send;
    logic [HW-1:0] header_pkt_send;
    logic          encap_done;
    logic          busy;
    logic [DW-1:0] fifo_dout;
    logic          fifo_empty;
    logic          fifo_rd_en;
    logic [DW-1:0] tx_data;
    logic          tx_valid;
    logic          tx_ready;
    logic          tx_last;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pkt_encapsulator #(
        .AURORA_DATA_WIDTH (DW),
        .ADDR_WIDTH        (AW),
        .HEADER_WIDTH      (HW),
        .LEN_WIDTH         (LW),
        .PAYLOAD_WORDS     (PW)
    ) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .start_encap_pkt      (start_encap_pkt),
        .router_dst_addr_send (router_dst_addr_send),
        .header_pkt_send      (header_pkt_send),
        .encap_done           (encap_done),
        .busy                 (busy),
        .fifo_dout            (fifo_dout),
        .fifo_empty           (fifo_empty),
        .fifo_rd_en           (fifo_rd_en),
        .tx_data              (tx_data),
        .tx_valid             (tx_valid),
        .tx_ready             (tx_ready),
        .tx_last              (tx_last)
    );

    // FWFT FIFO model: writer pointer owned by the stimulus, reader by the pop process
    logic [DW-1:0] fifo_mem [0:31];
    int wr_ptr  = 0;
    int rd_ptr  = 0;
    int pop_cnt = 0;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_dout  = fifo_empty ? '0 : fifo_mem[rd_ptr % 32];

    always @(posedge clk) begin
        if (fifo_rd_en && !fifo_empty) begin
            rd_ptr  <= rd_ptr + 1;
            pop_cnt <= pop_cnt + 1;
        end
    end

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } exp_t;
    exp_t exp_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] exp_hdr(input logic [AW-1:0] d, input logic [HW-1:0] h);
        logic [DW-AW-HW-LW-1:0] z;
        z = '0;
        return {d, h, 8'd4, z};
    endfunction

    task automatic push_word(input logic [DW-1:0] d);
        fifo_mem[wr_ptr % 32] = d;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic expect_packet(input logic [AW-1:0] d, input logic [HW-1:0] h, input logic [DW-1:0] base);
        exp_t e;
        e.data = exp_hdr(d, h);
        e.last = 1'b0;
        exp_q.push_back(e);
        for (int i = 0; i < PW; i++) begin
            e.data = base + DW'(i);
            e.last = (i == PW - 1);
            exp_q.push_back(e);
        end
    endtask

    // Monitor: scoreboard compare on transfers, stall stability, no pop without ready
    logic          stall_prev = 1'b0;
    logic [DW-1:0] prev_data  = '0;
    int            xfer_cnt   = 0;

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            stall_prev <= 1'b0;
        end else begin
            if (stall_prev) begin
                check("stall_valid", 64'(tx_valid), 64'(1'b1));
                check("stall_data", tx_data, prev_data);
            end
            if (tx_valid && tx_ready) begin
                xfer_cnt <= xfer_cnt + 1;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $error("FAIL unexpected_word: observed %h expected no transfer", tx_data);
                end else begin
                    e = exp_q.pop_front();
                    check("tx_data", tx_data, e.data);
                    check("tx_last", 64'(tx_last), 64'(e.last));
                    $display("xfer data=%h last=%0b", tx_data, tx_last);
                end
            end
            if (fifo_rd_en) begin
                check("pop_needs_ready", 64'(tx_ready), 64'(1'b1));
            end
            stall_prev <= tx_valid && !tx_ready;
            prev_data  <= tx_data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mode 0: always ready; mode 1: ready pattern 1,0,0. late_at pushes two words at that cycle.
    task automatic run_pkt(input int mode, input int late_at, input logic [DW-1:0] late_base,
                           input logic chg, output int cycles, output int gap);
        int  n;
        logic done;
        n    = 0;
        gap  = 0;
        done = 1'b0;
        start_encap_pkt = 1'b1;
        while (!done && n < 60) begin
            tick();
            n++;
            tx_ready = (mode == 1) ? ((n % 3) == 1) : 1'b1;
            if (n == late_at) begin
                push_word(late_base);
                push_word(late_base + 1);
            end
            if (chg && n == 1) begin
                router_dst_addr_send = ~router_dst_addr_send;
                header_pkt_send      = ~header_pkt_send;
            end
            @(negedge clk);
            if (encap_done) done = 1'b1;
            else if (!tx_valid && busy) gap++;
        end
        cycles = done ? n : -1;
        check("done_seen", 64'(done), 64'(1'b1));
    endtask

    task automatic finish_pkt(input int hold, input int pops_before);
        logic bad;
        tick();
        check("done_one_cycle", 64'(encap_done), 64'(1'b0));
        check("pops", 64'(pop_cnt - pops_before), 64'(PW));
        check("scoreboard_empty", 64'(exp_q.size()), 64'(0));
        bad = 1'b0;
        for (int i = 0; i < hold; i++) begin
            tick();
            if (busy !== 1'b1 || tx_valid !== 1'b0 || encap_done !== 1'b0) bad = 1'b1;
        end
        check("release_busy", 64'(busy), 64'(1'b1));
        if (hold > 0) check("held_no_retrigger", 64'(bad), 64'(1'b0));
        start_encap_pkt = 1'b0;
        tick();
        check("back_to_idle", 64'(busy), 64'(1'b0));
        $display("packet closed hold=%0d", hold);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int gap;
        int p0;

        rst_n = 1'b0;
        start_encap_pkt = 1'b0;
        tx_ready = 1'b0;
        router_dst_addr_send = '0;
        header_pkt_send = '0;
        repeat (3) tick();
        check("rst_tx_valid", 64'(tx_valid), 64'(1'b0));
        check("rst_tx_last", 64'(tx_last), 64'(1'b0));
        check("rst_rd_en", 64'(fifo_rd_en), 64'(1'b0));
        check("rst_done", 64'(encap_done), 64'(1'b0));
        check("rst_busy", 64'(busy), 64'(1'b0));
        check("rst_tx_data", tx_data, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("idle_busy", 64'(busy), 64'(1'b0));

        // Basic packet
        for (int i = 1; i <= PW; i++) push_word(DW'(i));
        router_dst_addr_send = 10'h155;
        header_pkt_send = 9'h0A2;
        expect_packet(10'h155, 9'h0A2, 64'h1);
        p0 = pop_cnt;
        run_pkt(0, 0, '0, 1'b0, cyc, gap);
        check("basic_latency", 64'(cyc), 64'(6));
        check("basic_gap", 64'(gap), 64'(0));
        finish_pkt(0, p0);

        // Backpressure
        for (int i = 0; i < PW; i++) push_word(64'h11 + DW'(i));
        router_dst_addr_send = 10'h2AA;
        header_pkt_send = 9'h155;
        expect_packet(10'h2AA, 9'h155, 64'h11);
        p0 = pop_cnt;
        run_pkt(1, 0, '0, 1'b0, cyc, gap);
        finish_pkt(0, p0);

        // FIFO underflow mid-payload
        push_word(64'h21);
        push_word(64'h22);
        router_dst_addr_send = 10'h0F0;
        header_pkt_send = 9'h00F;
        expect_packet(10'h0F0, 9'h00F, 64'h21);
        p0 = pop_cnt;
        run_pkt(0, 7, 64'h23, 1'b0, cyc, gap);
        check("underflow_latency", 64'(cyc), 64'(9));
        check("underflow_gap", 64'(gap), 64'(3));
        finish_pkt(0, p0);

        // Held request after completion
        for (int i = 0; i < PW; i++) push_word(64'h31 + DW'(i));
        router_dst_addr_send = 10'h001;
        header_pkt_send = 9'h100;
        expect_packet(10'h001, 9'h100, 64'h31);
        p0 = pop_cnt;
        run_pkt(0, 0, '0, 1'b0, cyc, gap);
        check("held_latency", 64'(cyc), 64'(6));
        finish_pkt(10, p0);

        // Reset after the 2nd payload word is accepted
        for (int i = 0; i < PW; i++) push_word(64'h41 + DW'(i));
        router_dst_addr_send = 10'h0AA;
        header_pkt_send = 9'h0AA;
        expect_packet(10'h0AA, 9'h0AA, 64'h41);
        tx_ready = 1'b1;
        start_encap_pkt = 1'b1;
        repeat (4) tick();
        check("pre_reset_xfers", 64'(xfer_cnt), 64'(xfer_cnt));
        rst_n = 1'b0;
        #1;
        check("mid_rst_tx_valid", 64'(tx_valid), 64'(1'b0));
        check("mid_rst_tx_last", 64'(tx_last), 64'(1'b0));
        check("mid_rst_rd_en", 64'(fifo_rd_en), 64'(1'b0));
        check("mid_rst_busy", 64'(busy), 64'(1'b0));
        check("mid_rst_tx_data", tx_data, 64'd0);
        check("mid_rst_sb_left", 64'(exp_q.size()), 64'(2));
        exp_q.delete();
        wr_ptr = rd_ptr;
        start_encap_pkt = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < PW; i++) push_word(64'h51 + DW'(i));
        router_dst_addr_send = 10'h3FF;
        header_pkt_send = 9'h1FF;
        expect_packet(10'h3FF, 9'h1FF, 64'h51);
        p0 = pop_cnt;
        run_pkt(0, 0, '0, 1'b0, cyc, gap);
        check("post_reset_latency", 64'(cyc), 64'(6));
        finish_pkt(0, p0);

        // Inputs changed one cycle after start
        for (int i = 0; i < PW; i++) push_word(64'h61 + DW'(i));
        router_dst_addr_send = 10'h0C3;
        header_pkt_send = 9'h11C;
        expect_packet(10'h0C3, 9'h11C, 64'h61);
        p0 = pop_cnt;
        run_pkt(0, 0, '0, 1'b1, cyc, gap);
        check("chg_latency", 64'(cyc), 64'(6));
        finish_pkt(0, p0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
